// File: rtl/pe_mem_arb_pkg.sv
// Shared types and default sizes for the PE-local SRAM port arbiter.
package pe_mem_arb_pkg;

    // Which requester owns an access or a returning read.
    typedef enum logic {
        SRC_DMA = 1'b0,
        SRC_LS  = 1'b1
    } pe_mem_src_e;

    // UNLOCKED: normal arbitration. DMA_LOCK: a DMA burst keeps the port.
    typedef enum logic {
        UNLOCKED = 1'b0,
        DMA_LOCK = 1'b1
    } pe_mem_arb_state_e;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_BURST_MAX = 16;

endpackage

// File: rtl/pe_mem_rd_tag_pipe.sv
// Read tag shift register: one stage per cycle of SRAM read latency, so the
// tag leaves the last stage in the same cycle its read data comes back.
module pe_mem_rd_tag_pipe
    import pe_mem_arb_pkg::*;
#(
    parameter int MEM_RD_LAT = 2
) (
    input  logic clk,
    input  logic reset_poweron,
    input  logic push_valid,
    input  logic push_src,
    output logic out_valid,
    output logic out_src
);

    logic [MEM_RD_LAT-1:0] valid_reg;
    logic [MEM_RD_LAT-1:0] src_reg;

    genvar gi;
    generate
        for (gi = 0; gi < MEM_RD_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // First stage captures the tag of the access issued this cycle.
                always_ff @(posedge clk) begin
                    if (reset_poweron) begin
                        valid_reg[0] <= 1'b0;
                        src_reg[0]   <= SRC_DMA;
                    end else begin
                        valid_reg[0] <= push_valid;
                        src_reg[0]   <= push_src;
                    end
                end
            end else begin : g_tail
                // Later stages just age the tag by one cycle.
                always_ff @(posedge clk) begin
                    if (reset_poweron) begin
                        valid_reg[gi] <= 1'b0;
                        src_reg[gi]   <= SRC_DMA;
                    end else begin
                        valid_reg[gi] <= valid_reg[gi-1];
                        src_reg[gi]   <= src_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = valid_reg[MEM_RD_LAT-1];
    assign out_src   = src_reg[MEM_RD_LAT-1];

endmodule

// File: rtl/pe_mem_port_arbiter.sv
// Shares one single-port SRAM between the DMA engine and the load/store unit.
// One access per cycle, DMA bursts stay contiguous up to BURST_MAX beats when
// load/store is waiting, and read data is steered back by a tag pipeline.
module pe_mem_port_arbiter
    import pe_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_RD_LAT = 2,
    parameter int BURST_MAX  = DEF_BURST_MAX
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic              dma_req_wr,
    input  logic              dma_req_last,
    input  logic [ADDR_W-1:0] dma_req_addr,
    input  logic [DATA_W-1:0] dma_req_wdata,
    output logic              dma_rsp_valid,
    output logic [DATA_W-1:0] dma_rsp_rdata,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic              ls_req_wr,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pe_mem_arb_state_e state_reg, state_next;
    logic [CNT_W-1:0]  burst_cnt_reg, burst_cnt_next;
    logic [CNT_W-1:0]  burst_inc;
    pe_mem_src_e       rr_src_reg, rr_src_next;
    logic              grant_dma;
    logic              grant_ls;
    logic              rd_push_valid;
    logic              rd_push_src;
    logic              tag_valid;
    logic              tag_src;

    // Arbitration state, burst counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_reg     <= UNLOCKED;
            burst_cnt_reg <= '0;
            rr_src_reg    <= SRC_DMA;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            rr_src_reg    <= rr_src_next;
        end
    end

    // Grant selection and lock transitions; nothing is granted during reset.
    always_comb begin
        grant_dma      = 1'b0;
        grant_ls       = 1'b0;
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        rr_src_next    = rr_src_reg;
        burst_inc      = (burst_cnt_reg >= CNT_MAX) ? CNT_MAX : burst_cnt_reg + CNT_ONE;
        if (!reset_poweron) begin
            case (state_reg)
                UNLOCKED: begin
                    if (dma_req_valid && ls_req_valid) begin
                        grant_dma   = (rr_src_reg == SRC_DMA);
                        grant_ls    = (rr_src_reg == SRC_LS);
                        rr_src_next = (rr_src_reg == SRC_DMA) ? SRC_LS : SRC_DMA;
                    end else begin
                        grant_dma = dma_req_valid;
                        grant_ls  = ls_req_valid;
                    end
                    if (grant_dma && !dma_req_last) begin
                        if (ls_req_valid && (CNT_ONE >= CNT_MAX)) begin
                            // A one-beat cap is already used up by this beat.
                            rr_src_next = SRC_LS;
                        end else begin
                            state_next     = DMA_LOCK;
                            burst_cnt_next = CNT_ONE;
                        end
                    end
                end
                DMA_LOCK: begin
                    grant_dma = dma_req_valid;
                    if (!dma_req_valid || dma_req_last) begin
                        // Bubble or end of burst hands the port back.
                        state_next     = UNLOCKED;
                        burst_cnt_next = '0;
                    end else if (ls_req_valid && (burst_inc == CNT_MAX)) begin
                        // Cap reached with load/store waiting: it goes next.
                        state_next     = UNLOCKED;
                        burst_cnt_next = '0;
                        rr_src_next    = SRC_LS;
                    end else begin
                        burst_cnt_next = burst_inc;
                    end
                end
                default: begin
                    state_next     = UNLOCKED;
                    burst_cnt_next = '0;
                end
            endcase
        end
    end

    // SRAM strobe and operands come straight from the granted beat.
    always_comb begin
        mem_cs    = grant_dma | grant_ls;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_dma) begin
            mem_we    = dma_req_wr;
            mem_addr  = dma_req_addr;
            mem_wdata = dma_req_wdata;
        end else if (grant_ls) begin
            mem_we    = ls_req_wr;
            mem_addr  = ls_req_addr;
            mem_wdata = ls_req_wdata;
        end
    end

    assign dma_req_ready = grant_dma;
    assign ls_req_ready  = grant_ls;

    assign rd_push_valid = (grant_dma & ~dma_req_wr) | (grant_ls & ~ls_req_wr);
    assign rd_push_src   = grant_ls ? SRC_LS : SRC_DMA;

    pe_mem_rd_tag_pipe #(
        .MEM_RD_LAT (MEM_RD_LAT)
    ) u_rd_tag_pipe (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .push_valid    (rd_push_valid),
        .push_src      (rd_push_src),
        .out_valid     (tag_valid),
        .out_src       (tag_src)
    );

    // Steer returning read data to its issuer; reset silences stale tags.
    assign dma_rsp_valid = tag_valid && (tag_src == SRC_DMA) && !reset_poweron;
    assign ls_rsp_valid  = tag_valid && (tag_src == SRC_LS) && !reset_poweron;
    assign dma_rsp_rdata = dma_rsp_valid ? mem_rdata : '0;
    assign ls_rsp_rdata  = ls_rsp_valid ? mem_rdata : '0;

endmodule

// File: doc/pe_mem_port_arbiter.md
Name: pe_mem_port_arbiter

Overview:
- Shares one single-port PE-local SRAM bank between two requesters: the DMA engine (dma2mem path) and the load/store unit (loadStore2memCntl path).
- Issues at most one memory access per cycle.
- Keeps DMA bursts contiguous, but caps them so load/store cannot starve.
- Routes read data back to the requester that issued the read, after a fixed SRAM latency.

Parameters:
- ADDR_W, 12, SRAM word address width
- DATA_W, 32, SRAM data width
- MEM_RD_LAT, 2, cycles from mem_cs/read issue to mem_rdata valid (range 1..4)
- BURST_MAX, 16, maximum consecutive DMA beats while load/store is waiting

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_poweron  in  1  synchronous, active-high reset
- dma_req_valid  in  1  DMA request present
- dma_req_ready  out  1  DMA request accepted this cycle
- dma_req_wr  in  1  1=write, 0=read
- dma_req_last  in  1  final beat of DMA burst
- dma_req_addr  in  ADDR_W  word address
- dma_req_wdata  in  DATA_W  write data
- dma_rsp_valid  out  1  read data for DMA
- dma_rsp_rdata  out  DATA_W  read data
- ls_req_valid  in  1  load/store request present (single beat)
- ls_req_ready  out  1  load/store request accepted
- ls_req_wr  in  1  1=store, 0=load
- ls_req_addr  in  ADDR_W  word address
- ls_req_wdata  in  DATA_W  store data
- ls_rsp_valid  out  1  load data valid
- ls_rsp_rdata  out  DATA_W  load data
- mem_cs  out  1  SRAM access strobe
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid MEM_RD_LAT cycles after read issue

Behaviour:
- Clock and reset: single clock, clk. reset_poweron is synchronous and active-high.
- Reset values:
  - All readys, rsp_valids and mem_cs/mem_we are 0.
  - mem_addr, mem_wdata and rsp_rdata are 0.
  - Lock is cleared, burst count is 0, and rr_next = SRC_DMA.
  - The read tag pipeline is flushed.
- Ready/accept: dma_req_ready and ls_req_ready are combinational from valid and state; at most one is 1 per cycle. A beat is accepted when valid and ready are both 1.
- Memory drive: mem_cs/mem_we/mem_addr/mem_wdata are combinational from the accepted beat, with zero added latency.
- Arbitration state machine, states UNLOCKED and DMA_LOCK:
  - UNLOCKED, only one valid: that requester is granted.
  - UNLOCKED, both valid: grant rr_next, then toggle rr_next.
  - UNLOCKED, DMA beat accepted with dma_req_last=0: go to DMA_LOCK with burst_cnt=1.
  - UNLOCKED, DMA beat accepted with dma_req_last=1: stay UNLOCKED.
  - DMA_LOCK: DMA holds priority and ls_req_ready=0; each accepted DMA beat increments burst_cnt.
  - DMA_LOCK exits to UNLOCKED (burst_cnt cleared) on any of:
    - a beat accepted with dma_req_last=1;
    - dma_req_valid=0 for one cycle (any bubble releases the lock);
    - burst_cnt reaches BURST_MAX with ls_req_valid=1. In this case rr_next is forced to SRC_LS so the next cycle grants load/store.
  - The burst then resumes through normal arbitration; the DMA engine re-requests with the remaining beats.
- Burst cap without contention: if burst_cnt reaches BURST_MAX while ls_req_valid=0, the lock is retained and the counter saturates at BURST_MAX until LS arrives or the burst ends.
- Read tag pipeline:
  - Each accepted read pushes {valid=1, src} into a MEM_RD_LAT-deep shift register; each accepted write pushes valid=0.
  - At the pipeline output, mem_rdata is registered-through combinationally into the selected rsp_rdata, and the matching rsp_valid is pulsed for one cycle.
  - Responses have no backpressure; requesters must sink them.
- Ordering: responses to each requester arrive in issue order. A read issued the cycle after a write to the same address returns the new data (SRAM write-first is guaranteed by the memory).
- Simultaneous events: when a response emerges and a new request is accepted in the same cycle, both proceed independently.
- Reset mid-operation: in-flight reads are discarded with no rsp_valid; the partial DMA burst is abandoned and the DMA engine restarts it.

Decomposition:
- Shared package pe_mem_arb_pkg holds:
  - typedef enum logic {SRC_DMA, SRC_LS} pe_mem_src_e
  - typedef enum logic {UNLOCKED, DMA_LOCK} pe_mem_arb_state_e
  - default ADDR_W/DATA_W/BURST_MAX localparams
- Sub-module pe_mem_rd_tag_pipe (parameter MEM_RD_LAT) holds the valid/src shift register, clear on reset_poweron.

Test Plan:
- Single DMA read of addr 0x010 (mem holds 0xDEADBEEF) -> mem_cs=1, mem_we=0 in cycle 0; dma_rsp_valid=1 with 0xDEADBEEF in cycle 2; ls_rsp_valid stays 0.
- DMA and LS single-beat reads both valid for 4 cycles from reset -> grants in order DMA, LS, DMA, LS; four responses each at +2 cycles, routed to the correct source.
- DMA 20-beat burst with LS read valid from beat 3 -> first 16 DMA beats accepted back-to-back, then LS granted in cycle 16, DMA resumes in cycle 17; LS data correct.
- LS store 0x12345678 to 0x020, then DMA read 0x020 on the next cycle -> dma_rsp_rdata=0x12345678.
- DMA burst with a one-cycle valid gap at beat 5 while LS waiting -> lock released, LS granted in the gap+1 cycle, DMA continues afterwards.
- reset_poweron asserted one cycle after two reads are issued -> no rsp_valid ever pulses for them; all outputs 0 next cycle; first post-reset contention grants DMA.
